// File: rtl/z_alu_seq.sv
// Registered MIPS ALU with valid/ready handshakes on both sides and an iterative
// shift-add unsigned multiplier that feeds the architectural HI/LO registers.
module z_alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [31:0]      ins_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [SHW-1:0]   shamt_in,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             err,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             valid_out,
    input  logic             ready_in
);

    typedef enum logic [0:0] {IDLE, MUL} state_t;

    state_t             state_reg, state_next;
    logic [SHW-1:0]     count_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   out_reg, hi_reg, lo_reg;
    logic               zero_reg, err_reg, valid_reg;

    logic [5:0]         opcode, funct;
    logic [15:0]        imm;
    logic [WIDTH-1:0]   sext_imm, zext_imm;
    logic [WIDTH-1:0]   res_next;
    logic               zero_next, err_next, is_mul, accept;
    logic [WIDTH-1:0]   partial;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;
    logic               mul_last;
    logic               unused_ins_bits;

    assign opcode          = ins_in[31:26];
    assign funct           = ins_in[5:0];
    assign imm             = ins_in[15:0];
    assign sext_imm        = WIDTH'($signed(imm));
    assign zext_imm        = WIDTH'(imm);
    assign unused_ins_bits = ^ins_in[25:16];

    // Instruction decode and single-cycle result.
    always_comb begin
        res_next  = '0;
        err_next  = 1'b0;
        is_mul    = 1'b0;
        zero_next = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21: res_next = a_in + b_in;
                    6'h23: res_next = a_in - b_in;
                    6'h24: res_next = a_in & b_in;
                    6'h25: res_next = a_in | b_in;
                    6'h27: res_next = ~(a_in | b_in);
                    6'h2A: res_next = WIDTH'($signed(a_in) < $signed(b_in));
                    6'h2B: res_next = WIDTH'(a_in < b_in);
                    6'h00: res_next = a_in << shamt_in;
                    6'h02: res_next = a_in >> shamt_in;
                    6'h19: is_mul   = 1'b1;
                    6'h10: res_next = hi_reg;
                    6'h12: res_next = lo_reg;
                    default: err_next = 1'b1;
                endcase
                zero_next = !err_next && (res_next == '0);
            end
            6'h09, 6'h23, 6'h2B: begin
                res_next  = a_in + sext_imm;
                zero_next = (res_next == '0);
            end
            6'h0C: begin
                res_next  = a_in & zext_imm;
                zero_next = (res_next == '0);
            end
            6'h0D: begin
                res_next  = a_in | zext_imm;
                zero_next = (res_next == '0);
            end
            6'h0A: begin
                res_next  = WIDTH'($signed(a_in) < $signed(sext_imm));
                zero_next = (res_next == '0);
            end
            // Branches report "taken" on the zero flag rather than result==0.
            6'h04: begin
                res_next  = a_in - b_in;
                zero_next = (a_in == b_in);
            end
            6'h05: begin
                res_next  = a_in - b_in;
                zero_next = (a_in != b_in);
            end
            default: err_next = 1'b1;
        endcase
    end

    // One shift-add step: add multiplicand into the upper half, shift the whole
    // accumulator right; after WIDTH steps it holds the full product.
    assign partial  = mplier_reg[0] ? mcand_reg : '0;
    assign sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, partial};
    assign acc_next = {sum, acc_reg[WIDTH-1:1]};
    assign mul_last = (count_reg == SHW'(WIDTH - 1));
    assign accept   = valid_in && ready_out;

    always_comb begin
        state_next = state_reg;
        ready_out  = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_out = !rst_in && (!valid_reg || ready_in);
                if (valid_in && ready_out && is_mul)
                    state_next = MUL;
            end
            MUL: begin
                if (mul_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            out_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            zero_reg   <= 1'b0;
            err_reg    <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            mcand_reg  <= a_in;
                            mplier_reg <= b_in;
                            acc_reg    <= '0;
                            count_reg  <= '0;
                            valid_reg  <= 1'b0;
                        end else begin
                            out_reg   <= res_next;
                            zero_reg  <= zero_next;
                            err_reg   <= err_next;
                            valid_reg <= 1'b1;
                        end
                    end else if (valid_reg && ready_in) begin
                        valid_reg <= 1'b0;
                    end
                end
                MUL: begin
                    acc_reg    <= acc_next;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= mul_last ? '0 : count_reg + 1'b1;
                    if (mul_last) begin
                        hi_reg    <= acc_next[2*WIDTH-1:WIDTH];
                        lo_reg    <= acc_next[WIDTH-1:0];
                        out_reg   <= acc_next[WIDTH-1:0];
                        zero_reg  <= (acc_next == '0);
                        err_reg   <= 1'b0;
                        valid_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out       = out_reg;
    assign zero      = zero_reg;
    assign err       = err_reg;
    assign hi_out    = hi_reg;
    assign lo_out    = lo_reg;
    assign valid_out = valid_reg;

endmodule
